sync_updn_counter: RTL and testbench

- Parametrised synchronous up/down counter, modulo-N, built as a T-flip-flop array with per-bit toggle enables.
- Successor to the fixed 4-bit down counter:
  - adds generic width and modulus;
  - runtime direction, count enable and parallel load;
  - terminal-count and wrap outputs.
- Used as the timebase/sequence counter for the lab-board datapaths and cascadable through tc.

---
 rtl/cnt_pkg.sv | 15 +
 rtl/tff_cell.sv | 17 +
 rtl/sync_updn_counter.sv | 95 +++++++++
 tb/tb_sync_updn_counter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types, constants and configuration check for sync_updn_counter
package cnt_pkg;

    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_t;

    localparam int CNT_MAX_WIDTH = 16;

    // Width must hold every count 0..modulus-1 without exceeding the supported range.
    function automatic bit cnt_cfg_ok(input int width, input longint modulus);
        return (width >= 2) && (width <= CNT_MAX_WIDTH) &&
               (modulus >= 2) && (modulus <= (longint'(1) << width)) &&
               ($clog2(modulus) <= width);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop with asynchronous active-low reset
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/sync_updn_counter.sv
// rtl/sync_updn_counter.sv - modulo-N up/down counter on a T-flop array; SYNC_UPDN_SATURATE_EN selects saturation
module sync_updn_counter
    import cnt_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    if (!cnt_cfg_ok(WIDTH, longint'(MODULUS))) begin : g_bad_cfg
        $error("sync_updn_counter: unsupported WIDTH/MODULUS combination");
    end

    cnt_dir_t         dir;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] toggle;
`ifndef SYNC_UPDN_SATURATE_EN
    logic             wrap_nxt;
`endif

    assign dir = cnt_dir_t'(up_dn);

    always_comb begin
        q_nxt = q;
`ifndef SYNC_UPDN_SATURATE_EN
        wrap_nxt = 1'b0;
`endif
        if (load) begin
            q_nxt = (32'(load_val) >= MODULUS) ? Q_MAX : load_val;
        end else if (en) begin
            if (dir == CNT_UP) begin
                if (q == Q_MAX) begin
`ifdef SYNC_UPDN_SATURATE_EN
                    q_nxt = Q_MAX;
`else
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q + 1'b1;
                end
            end else begin
                if (q == '0) begin
`ifdef SYNC_UPDN_SATURATE_EN
                    q_nxt = '0;
`else
                    q_nxt    = Q_MAX;
                    wrap_nxt = 1'b1;
`endif
                end else begin
                    q_nxt = q - 1'b1;
                end
            end
        end
    end

    // Each bit flips exactly where the next state differs, keeping a pure T-flop array
    // even when MODULUS is not a power of two.
    assign toggle = q_nxt ^ q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_cell u_tff (
            .clk   (clk),
            .reset (reset),
            .t     (toggle[i]),
            .q     (q[i])
        );
    end

    assign tc = en & ~load & ((up_dn & (q == Q_MAX)) | (~up_dn & (q == '0)));

`ifdef SYNC_UPDN_SATURATE_EN
    assign wrap = 1'b0;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sync_updn_counter.sv
// tb/tb_sync_updn_counter.sv - randomized self-checking bench for sync_updn_counter (MODULUS 10 and 16)
module tb_sync_updn_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q_a, q_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    logic [3:0] qv  [2];
    logic       tcv [2];
    logic       wv  [2];

    int n_checks = 0;
    int n_fail   = 0;

    int mq [2];
    bit mw [2];
    int mm [2] = '{10, 16};

    always #5 clk = ~clk;

    sync_updn_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_a), .tc(tc_a), .wrap(wrap_a)
    );

    sync_updn_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q_b), .tc(tc_b), .wrap(wrap_b)
    );

    assign qv[0]  = q_a;
    assign qv[1]  = q_b;
    assign tcv[0] = tc_a;
    assign tcv[1] = tc_b;
    assign wv[0]  = wrap_a;
    assign wv[1]  = wrap_b;

    // Reference: modular step of +/-1, wrap flagged when the step crosses the range end.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int  m;
            int  nxt;
            bit  crossed;
            m = mm[k];
            if (!reset) begin
                mq[k] = 0;
                mw[k] = 1'b0;
            end else if (load) begin
                mq[k] = (int'(load_val) < m) ? int'(load_val) : m - 1;
                mw[k] = 1'b0;
            end else if (en) begin
                nxt     = (mq[k] + (up_dn ? 1 : -1) + m) % m;
                crossed = up_dn ? (mq[k] + 1 == m) : (mq[k] == 0);
`ifdef SYNC_UPDN_SATURATE_EN
                if (!crossed) mq[k] = nxt;
                mw[k] = 1'b0;
`else
                mq[k] = nxt;
                mw[k] = crossed;
`endif
            end else begin
                mw[k] = 1'b0;
            end
        end
    endtask

    function automatic bit model_tc(int k);
        return en && !load && ((up_dn && mq[k] == mm[k] - 1) || (!up_dn && mq[k] == 0));
    endfunction

    task automatic drive(input logic e, input logic u, input logic l, input logic [3:0] v);
        en = e; up_dn = u; load = l; load_val = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // One cycle: check tc before the edge, then q and wrap after it.
    task automatic cycle(input logic e, input logic u, input logic l, input logic [3:0] v);
        drive(e, u, l, v);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (tcv[k] !== model_tc(k)) begin
                n_fail++;
                $display("FAIL tc[%0d] t=%0t: got %b expected %b", k, $time, tcv[k], model_tc(k));
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            n_checks += 2;
            if (qv[k] !== 4'(mq[k])) begin
                n_fail++;
                $display("FAIL q[%0d] t=%0t: got %0d expected %0d", k, $time, qv[k], mq[k]);
            end
            if (wv[k] !== mw[k]) begin
                n_fail++;
                $display("FAIL wrap[%0d] t=%0t: got %b expected %b", k, $time, wv[k], mw[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd0);
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (qv[k] !== 4'd0 || wv[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got q=%0d wrap=%b expected q=0 wrap=0", k, qv[k], wv[k]);
            end
        end
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    endtask

    task automatic test_count_up();
        logic [3:0] exp_a [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        cycle(1'b0, 1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 4'd0);
`ifndef SYNC_UPDN_SATURATE_EN
            n_checks++;
            if (q_a !== exp_a[i] || wrap_a !== (i == 9)) begin
                n_fail++;
                $display("FAIL up_seq step %0d: got q=%0d wrap=%b expected q=%0d wrap=%b",
                         i, q_a, wrap_a, exp_a[i], (i == 9));
            end
`endif
        end
    endtask

    task automatic test_count_down();
        cycle(1'b0, 1'b0, 1'b1, 4'd1);
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_load_clamp();
        cycle(1'b1, 1'b1, 1'b1, 4'd13);
        n_checks++;
        if (q_a !== 4'd9 || wrap_a !== 1'b0) begin
            n_fail++;
            $display("FAIL load_clamp: got q=%0d wrap=%b expected q=9 wrap=0", q_a, wrap_a);
        end
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b1, 1'b1, 4'd15);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_direction_change();
        cycle(1'b0, 1'b1, 1'b1, 4'd5);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b1, 1'b1, 4'd6);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (qv[k] !== 4'd0 || wv[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got q=%0d wrap=%b expected q=0 wrap=0", k, qv[k], wv[k]);
            end
            mq[k] = 0;
            mw[k] = 1'b0;
        end
        @(negedge clk);
        cycle(1'b1, 1'b1, 1'b0, 4'd0);
        reset = 1'b1;
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic test_saturate_edges();
        cycle(1'b0, 1'b1, 1'b1, 4'd14);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 4'd0);
        cycle(1'b0, 1'b0, 1'b1, 4'd1);
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        @(negedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_direction_change();
        test_async_reset();
        test_saturate_edges();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
